// File: rtl/prefix_pkg.sv
// Shared constants and helpers for the prefix adder/subtractor family.
// Level counts are functions so each instance can size itself from its own WIDTH.
package prefix_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int SUB_LAT   = 3;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

    function automatic int prefix_levels(input int width);
        return clog2(width);
    endfunction

    // Levels 1..split_level run ahead of the first register, the rest after it.
    function automatic int split_level(input int width);
        return (clog2(width) + 1) / 2;
    endfunction

    localparam int L     = prefix_levels(DEF_WIDTH);
    localparam int SPLIT = split_level(DEF_WIDTH);

endpackage

// File: rtl/prefix_merge_cell.sv
// Kogge-Stone (G,P) merge: combines a high group with the adjacent lower group.
module prefix_merge_cell (
    input  logic g_hi,
    input  logic p_hi,
    input  logic g_lo,
    input  logic p_lo,
    output logic g_o,
    output logic p_o
);

    assign g_o = g_hi | (p_hi & g_lo);
    assign p_o = p_hi & p_lo;

endmodule

// File: rtl/prefix_sub_pipe.sv
// Three-stage pipelined Kogge-Stone subtractor (a + ~b + 1) with valid/ready on
// both sides, producing difference, borrow, zero and signed-overflow flags.
module prefix_sub_pipe
    import prefix_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_diff,
    output logic             out_borrow,
    output logic             out_zero,
    output logic             out_ovf,
    output logic [TAG_W-1:0] out_tag
);

    localparam int LVLS = prefix_levels(WIDTH);
    localparam int SPL  = split_level(WIDTH);

    logic             ld1, ld2, ld3, accept;
    logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [WIDTH-1:0] s1_g_q, s1_g_d, s1_p_q, s1_p_d, s1_pv_q, s1_pv_d;
    logic             s1_amsb_q, s1_amsb_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic [WIDTH-1:0] s2_c_q, s2_c_d, s2_pv_q, s2_pv_d;
    logic             s2_amsb_q, s2_amsb_d, s2_zero_q, s2_zero_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d, zero_q, zero_d, ovf_q, ovf_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    logic [WIDTH-1:0] g_in, p_in;
    assign g_in = in_a & ~in_b;
    assign p_in = in_a ^ ~in_b;

    genvar gl, gi;
    for (gl = 0; gl <= LVLS; gl++) begin : gen_lvl
        logic [WIDTH-1:0] g_o, p_o;
        if (gl == 0) begin : gen_base
            // Carry-in of 1 is absorbed into bit 0's generate.
            assign g_o = {g_in[WIDTH-1:1], g_in[0] | p_in[0]};
            assign p_o = p_in;
        end else begin : gen_merge
            localparam int SPAN = 1 << (gl - 1);
            logic [WIDTH-1:0] g_src, p_src;
            if (gl == SPL + 1) begin : gen_from_reg
                assign g_src = s1_g_q;
                assign p_src = s1_p_q;
            end else begin : gen_from_comb
                assign g_src = gen_lvl[gl-1].g_o;
                assign p_src = gen_lvl[gl-1].p_o;
            end
            for (gi = 0; gi < WIDTH; gi++) begin : gen_bit
                if (gi < SPAN) begin : gen_pass
                    assign g_o[gi] = g_src[gi];
                    assign p_o[gi] = p_src[gi];
                end else begin : gen_cell
                    prefix_merge_cell u_cell (
                        .g_hi(g_src[gi]),
                        .p_hi(p_src[gi]),
                        .g_lo(g_src[gi-SPAN]),
                        .p_lo(p_src[gi-SPAN]),
                        .g_o (g_o[gi]),
                        .p_o (p_o[gi])
                    );
                end
            end
        end
    end

    // Each stage loads when empty or when it hands its contents downstream.
    assign ld3      = ~v3_q | out_ready;
    assign ld2      = ~v2_q | ld3;
    assign ld1      = ~v1_q | ld2;
    assign in_ready = ld1 & ~rst;
    assign accept   = in_valid & in_ready;

    always_comb begin
        v1_d      = ld1 ? accept : v1_q;
        v2_d      = ld2 ? v1_q : v2_q;
        v3_d      = ld3 ? v2_q : v3_q;

        s1_g_d    = s1_g_q;
        s1_p_d    = s1_p_q;
        s1_pv_d   = s1_pv_q;
        s1_amsb_d = s1_amsb_q;
        s1_tag_d  = s1_tag_q;
        if (accept) begin
            s1_g_d    = gen_lvl[SPL].g_o;
            s1_p_d    = gen_lvl[SPL].p_o;
            s1_pv_d   = p_in;
            s1_amsb_d = in_a[WIDTH-1];
            s1_tag_d  = in_tag;
        end

        s2_c_d    = s2_c_q;
        s2_pv_d   = s2_pv_q;
        s2_amsb_d = s2_amsb_q;
        s2_zero_d = s2_zero_q;
        s2_tag_d  = s2_tag_q;
        if (ld2 && v1_q) begin
            s2_c_d    = gen_lvl[LVLS].g_o;
            s2_pv_d   = s1_pv_q;
            s2_amsb_d = s1_amsb_q;
            // Full-span group propagate is set only when every bit of a equals b.
            s2_zero_d = &gen_lvl[LVLS].p_o;
            s2_tag_d  = s1_tag_q;
        end

        diff_d   = diff_q;
        borrow_d = borrow_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        tag_d    = tag_q;
        if (ld3 && v2_q) begin
            diff_d   = s2_pv_q ^ {s2_c_q[WIDTH-2:0], 1'b1};
            borrow_d = ~s2_c_q[WIDTH-1];
            zero_d   = s2_zero_q;
            // p[MSB] low means the operand signs differ.
            ovf_d    = ~s2_pv_q[WIDTH-1] & (diff_d[WIDTH-1] ^ s2_amsb_q);
            tag_d    = s2_tag_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            v3_q      <= 1'b0;
            s1_g_q    <= '0;
            s1_p_q    <= '0;
            s1_pv_q   <= '0;
            s1_amsb_q <= 1'b0;
            s1_tag_q  <= '0;
            s2_c_q    <= '0;
            s2_pv_q   <= '0;
            s2_amsb_q <= 1'b0;
            s2_zero_q <= 1'b0;
            s2_tag_q  <= '0;
            diff_q    <= '0;
            borrow_q  <= 1'b0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            tag_q     <= '0;
        end else begin
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            v3_q      <= v3_d;
            s1_g_q    <= s1_g_d;
            s1_p_q    <= s1_p_d;
            s1_pv_q   <= s1_pv_d;
            s1_amsb_q <= s1_amsb_d;
            s1_tag_q  <= s1_tag_d;
            s2_c_q    <= s2_c_d;
            s2_pv_q   <= s2_pv_d;
            s2_amsb_q <= s2_amsb_d;
            s2_zero_q <= s2_zero_d;
            s2_tag_q  <= s2_tag_d;
            diff_q    <= diff_d;
            borrow_q  <= borrow_d;
            zero_q    <= zero_d;
            ovf_q     <= ovf_d;
            tag_q     <= tag_d;
        end
    end

    assign out_valid  = v3_q;
    assign out_diff   = diff_q;
    assign out_borrow = borrow_q;
    assign out_zero   = zero_q;
    assign out_ovf    = ovf_q;
    assign out_tag    = tag_q;

endmodule

// File: tb/tb_prefix_sub_pipe.sv
// Scoreboard bench for prefix_sub_pipe: the driver queues expected results on
// accept, an independent monitor pops and compares every consumed output.
module tb_prefix_sub_pipe;

    typedef struct packed {
        logic [31:0] diff;
        logic        borrow;
        logic        zero;
        logic        ovf;
        logic [3:0]  tag;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_diff;
    logic        out_borrow;
    logic        out_zero;
    logic        out_ovf;
    logic [3:0]  out_tag;

    exp_t sb[$];
    int   checks    = 0;
    int   errors    = 0;
    int   acc_cnt   = 0;
    int   out_cnt   = 0;
    int   stall_cnt = 0;

    prefix_sub_pipe #(.WIDTH(32), .TAG_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_diff  (out_diff),
        .out_borrow(out_borrow),
        .out_zero  (out_zero),
        .out_ovf   (out_ovf),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [31:0] d, input logic bo, input logic z,
                                input logic o, input logic [3:0] t);
        exp_t e;
        e.diff = d; e.borrow = bo; e.zero = z; e.ovf = o; e.tag = t;
        return e;
    endfunction

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [3:0] t);
        logic [31:0] d;
        d = a - b;
        return mk(d, a < b, d == 32'd0, (a[31] != b[31]) && (d[31] != a[31]), t);
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    // Drives one operand pair from posedge+1 and holds it until accepted.
    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] t, input exp_t e);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_tag   = t;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                acc_cnt++;
                break;
            end
            stall_cnt++;
            if (n >= 60) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: got in_ready=0 for %0d cycles, required accept (tag %0d)", n, t);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = 'x;
        in_b     = 'x;
    endtask

    task automatic drain();
        for (int n = 0; n < 200 && sb.size() != 0; n++) @(negedge clk);
        chk("drain_pending", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: every consumed output is matched against the head of the scoreboard.
    exp_t mon_exp;
    exp_t mon_got;
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            out_cnt++;
            checks++;
            mon_got = mk(out_diff, out_borrow, out_zero, out_ovf, out_tag);
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got diff=%h tag=%0d, required no output",
                         out_diff, out_tag);
            end else begin
                mon_exp = sb.pop_front();
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL result: got diff=%h b=%b z=%b o=%b tag=%0d, required diff=%h b=%b z=%b o=%b tag=%0d",
                             mon_got.diff, mon_got.borrow, mon_got.zero, mon_got.ovf, mon_got.tag,
                             mon_exp.diff, mon_exp.borrow, mon_exp.zero, mon_exp.ovf, mon_exp.tag);
                end else begin
                    $display("out tag=%0d diff=%h borrow=%b zero=%b ovf=%b ok",
                             out_tag, out_diff, out_borrow, out_zero, out_ovf);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base_acc;
        int base_out;
        logic [31:0] ra, rb;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = 'x;
        in_b      = 'x;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_outputs", 64'({out_diff, out_borrow, out_zero, out_ovf, out_tag}), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_reset", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Basic subtraction with a latency check of exactly three cycles.
        send(32'd5, 32'd3, 4'hA, mk(32'd2, 1'b0, 1'b0, 1'b0, 4'hA));
        @(negedge clk); chk("latency_c1", 64'(out_valid), 64'd0);
        @(negedge clk); chk("latency_c2", 64'(out_valid), 64'd0);
        @(negedge clk); chk("latency_c3", 64'(out_valid), 64'd1);
        drain();
        @(posedge clk);
        #1;

        // Directed boundaries, hand-computed.
        send(32'd3,        32'd5,        4'd1, mk(32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 4'd1));
        send(32'd0,        32'd1,        4'd2, mk(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 4'd2));
        send(32'h8000_0000, 32'd1,       4'd3, mk(32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 4'd3));
        send(32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'd4, mk(32'd0,       1'b0, 1'b1, 1'b0, 4'd4));
        send(32'h1234_5678, 32'd0,       4'd5, mk(32'h1234_5678, 1'b0, 1'b0, 1'b0, 4'd5));
        send(32'h7FFF_FFFF, 32'hFFFF_FFFF, 4'd6, mk(32'h8000_0000, 1'b1, 1'b0, 1'b1, 4'd6));
        drain();
        @(posedge clk);
        #1;

        // Throughput: 100 back-to-back random pairs must never see in_ready low.
        stall_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            ra = $urandom;
            rb = $urandom;
            send(ra, rb, 4'(i % 16), model(ra, rb, 4'(i % 16)));
        end
        chk("throughput_stalls", 64'(stall_cnt), 64'd0);
        drain();
        @(posedge clk);
        #1;

        // Backpressure: five offered, three fit, the rest follow once released.
        out_ready = 1'b0;
        base_acc  = acc_cnt;
        base_out  = out_cnt;
        fork
            begin
                send(32'd100,       32'd1,  4'd7,  mk(32'd99,         1'b0, 1'b0, 1'b0, 4'd7));
                send(32'd200,       32'd50, 4'd8,  mk(32'd150,        1'b0, 1'b0, 1'b0, 4'd8));
                send(32'd7,         32'd9,  4'd9,  mk(32'hFFFF_FFFE,  1'b1, 1'b0, 1'b0, 4'd9));
                send(32'd0,         32'd0,  4'd10, mk(32'd0,          1'b0, 1'b1, 1'b0, 4'd10));
                send(32'hFFFF_FFFF, 32'd1,  4'd11, mk(32'hFFFF_FFFE,  1'b0, 1'b0, 1'b0, 4'd11));
            end
            begin
                repeat (8) @(negedge clk);
                chk("bp_accepted", 64'(acc_cnt - base_acc), 64'd3);
                chk("bp_in_ready_low", 64'(in_ready), 64'd0);
                chk("bp_out_valid", 64'(out_valid), 64'd1);
                chk("bp_out_held", 64'({out_diff, out_tag}), 64'({32'd99, 4'd7}));
                repeat (3) @(negedge clk);
                chk("bp_out_stable", 64'({out_diff, out_borrow, out_zero, out_ovf, out_tag}),
                    64'({32'd99, 1'b0, 1'b0, 1'b0, 4'd7}));
                chk("bp_none_consumed", 64'(out_cnt - base_out), 64'd0);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_all_out", 64'(out_cnt - base_out), 64'd5);
        @(posedge clk);
        #1;

        // Reset with two operations in flight: both must vanish.
        out_ready = 1'b0;
        send(32'd11, 32'd1, 4'd12, mk(32'd10, 1'b0, 1'b0, 1'b0, 4'd12));
        send(32'd22, 32'd2, 4'd13, mk(32'd20, 1'b0, 1'b0, 1'b0, 4'd13));
        base_out = out_cnt;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_in_ready_low", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_outputs", 64'({out_diff, out_borrow, out_zero, out_ovf, out_tag}), 64'd0);
        chk("rst_in_ready_after", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("rst_discarded", 64'(out_cnt - base_out), 64'd0);
        @(posedge clk);
        #1;

        send(32'd9, 32'd4, 4'd14, mk(32'd5, 1'b0, 1'b0, 1'b0, 4'd14));
        drain();
        chk("post_rst_out", 64'(out_cnt - base_out), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
